// File: rtl/ltpi_pkg.sv
// LTPI shared types: data-channel payload, link states and the constants used
// by the target-side data-channel bridge.
package ltpi_pkg;

    localparam int TIMER_1MS_60MHZ = 60000;

    typedef enum logic [3:0] {
        link_detect_st  = 4'd0,
        link_speed_st   = 4'd1,
        advertise_st    = 4'd2,
        configure_st    = 4'd3,
        accept_st       = 4'd4,
        operational_st  = 4'd5,
        link_lost_st    = 4'd6
    } link_state_t;

    typedef enum logic [7:0] {
        READ_REQ   = 8'h00,
        WRITE_REQ  = 8'h01,
        CRC_ERROR  = 8'h02,
        READ_COMP  = 8'h03,
        WRITE_COMP = 8'h04
    } dc_command_t;

    typedef struct packed {
        logic [7:0]  tag;
        dc_command_t command;
        logic [31:0] address;
        logic [7:0]  status;
        logic [3:0]  byte_en;
        logic [31:0] data;
    } Data_channel_payload_t;

    localparam logic [7:0] DC_STATUS_OK  = 8'h00;
    localparam logic [7:0] DC_STATUS_ERR = 8'h01;
    localparam logic [1:0] AVM_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} dc_state_t;

    // Expands a 4-bit byte enable into a 32-bit lane mask.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/ltpi_dc_req_fifo.sv
// Synchronous request FIFO with first-word fall-through read and a flush
// that empties it in one cycle.
module ltpi_dc_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == FULL_LVL);
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A push into a full queue still lands when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only ever read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ltpi_dc_target_bridge.sv
// Target-side LTPI data-channel bridge: queues received requests, runs them as
// Avalon-MM master cycles and returns tagged completions.
module ltpi_dc_target_bridge
    import ltpi_pkg::*;
#(
    parameter int          REQ_FIFO_DEPTH = 4,
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter int          ADDR_SIZE      = 64,
    parameter int          TIMEOUT_CYCLES = TIMER_1MS_60MHZ,
    parameter int          CNT_W          = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              data_channel_rst,
    input  link_state_t                       local_link_state,
    input  Data_channel_payload_t             req_i,
    input  logic                              req_i_valid,
    input  logic                              frm_crc_error,
    output Data_channel_payload_t             resp,
    output logic                              resp_valid,
    input  logic                              resp_ack,
    output logic [31:0]                       avm_address,
    output logic                              avm_read,
    output logic                              avm_write,
    output logic [31:0]                       avm_writedata,
    output logic [3:0]                        avm_byteenable,
    input  logic                              avm_waitrequest,
    input  logic [31:0]                       avm_readdata,
    input  logic                              avm_readdatavalid,
    input  logic                              avm_writeresponsevalid,
    input  logic [1:0]                        avm_response,
    output logic [$clog2(REQ_FIFO_DEPTH):0]   q_level,
    output logic [CNT_W-1:0]                  drop_cnt,
    output logic [CNT_W-1:0]                  timeout_cnt
);
    localparam int               ENTRY_W  = $bits(Data_channel_payload_t) + 1;
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [32:0]      WIN_SIZE = 33'(ADDR_SIZE);

    dc_state_t             state, state_n;
    Data_channel_payload_t head, cur, resp_n;
    logic [ENTRY_W-1:0]    head_entry;
    logic                  head_crc, fifo_full, fifo_empty;
    logic                  link_op, push, pop, drop;
    logic [TMR_W-1:0]      tmr;
    logic [32:0]           offset;
    logic                  in_window, cmd_ok, cur_is_read, busy;
    logic                  abort_q, aborting, to_hit, done, timed_out;
    logic                  load_bus, load_resp;

    assign link_op = (local_link_state == operational_st);
    assign push    = req_i_valid & link_op;
    assign pop     = (state == IDLE) & ~fifo_empty & link_op;
    assign drop    = push & fifo_full & ~pop;

    ltpi_dc_req_fifo #(.WIDTH(ENTRY_W), .DEPTH(REQ_FIFO_DEPTH)) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (data_channel_rst | ~link_op),
        .push    (push),
        .wr_data ({req_i, frm_crc_error}),
        .pop     (pop),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (q_level)
    );

    assign {head, head_crc} = head_entry;
    // 33-bit offset so an address below ADDR_BASE wraps to a huge value and fails the window.
    assign offset    = {1'b0, head.address} - {1'b0, ADDR_BASE};
    assign in_window = (offset < WIN_SIZE);
    assign cmd_ok    = (head.command == READ_REQ) | (head.command == WRITE_REQ);

    assign cur_is_read = (cur.command == READ_REQ);
    assign busy        = (state == ISSUE) | (state == WAIT);
    assign aborting    = abort_q | ~link_op;
    assign to_hit      = (tmr == TMR_LAST);
    assign done        = (state == WAIT) &
                         (cur_is_read ? avm_readdatavalid : avm_writeresponsevalid);
    assign timed_out   = busy & to_hit & ~done;

    assign avm_address    = cur.address;
    assign avm_byteenable = cur.byte_en;
    assign avm_read       = (state == ISSUE) & cur_is_read & ~to_hit;
    assign avm_write      = (state == ISSUE) & ~cur_is_read & ~to_hit;
    assign resp_valid     = (state == RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 state <= IDLE;
        else if (data_channel_rst) state <= IDLE;
        else                       state <= state_n;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n   = state;
        resp_n    = cur;
        load_bus  = 1'b0;
        load_resp = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    resp_n        = head;
                    resp_n.status = DC_STATUS_ERR;
                    resp_n.data   = '0;
                    if (head_crc) begin
                        resp_n.command = CRC_ERROR;
                        load_resp      = 1'b1;
                        state_n        = RESP;
                    end else if (!in_window || !cmd_ok) begin
                        if (head.command == WRITE_REQ) resp_n.command = WRITE_COMP;
                        else                           resp_n.command = READ_COMP;
                        load_resp = 1'b1;
                        state_n   = RESP;
                    end else begin
                        load_bus = 1'b1;
                        state_n  = ISSUE;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (done || timed_out) begin
                    if (cur_is_read) resp_n.command = READ_COMP;
                    else             resp_n.command = WRITE_COMP;
                    if (done) begin
                        resp_n.status = (avm_response != AVM_RESP_OKAY) ? DC_STATUS_ERR : DC_STATUS_OK;
                        resp_n.data   = cur_is_read ? (avm_readdata & be_mask(cur.byte_en))
                                                    : avm_writedata;
                    end else begin
                        resp_n.status = DC_STATUS_ERR;
                        resp_n.data   = '0;
                    end
                    if (aborting) begin
                        state_n = IDLE;
                    end else begin
                        load_resp = 1'b1;
                        state_n   = RESP;
                    end
                end else if (state == ISSUE && !avm_waitrequest) begin
                    state_n = WAIT;
                end
            end
            RESP: begin
                if (!link_op || resp_ack) state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur           <= '0;
            avm_writedata <= '0;
            resp          <= '0;
            tmr           <= '0;
            abort_q       <= 1'b0;
            drop_cnt      <= '0;
            timeout_cnt   <= '0;
        end else if (data_channel_rst) begin
            cur           <= '0;
            avm_writedata <= '0;
            resp          <= '0;
            tmr           <= '0;
            abort_q       <= 1'b0;
            drop_cnt      <= '0;
            timeout_cnt   <= '0;
        end else begin
            if (load_bus) begin
                cur           <= head;
                avm_writedata <= head.data & be_mask(head.byte_en);
            end
            if (load_resp) resp <= resp_n;
            if (load_bus)  tmr <= '0;
            else if (busy) tmr <= tmr + 1'b1;
            // An in-flight cycle that saw the link drop completes silently.
            abort_q <= (state_n != IDLE) & (abort_q | ~link_op);
            if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
            if (timed_out && !aborting && !(&timeout_cnt)) timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ltpi_dc_target_bridge.sv
// Scoreboard bench for ltpi_dc_target_bridge: directed requests push expected
// completions, a monitor pops and compares, an Avalon slave model answers.
module tb_ltpi_dc_target_bridge;
    import ltpi_pkg::*;

    localparam int DEPTH = 4;
    localparam int TOUT  = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  data_channel_rst = 1'b0;
    link_state_t           link = operational_st;
    Data_channel_payload_t req_i = '0;
    logic                  req_i_valid = 1'b0;
    logic                  frm_crc_error = 1'b0;
    Data_channel_payload_t resp;
    logic                  resp_valid;
    logic                  resp_ack = 1'b0;
    logic [31:0]           avm_address, avm_writedata;
    logic                  avm_read, avm_write;
    logic [3:0]            avm_byteenable;
    logic                  avm_waitrequest = 1'b0;
    logic [31:0]           avm_readdata = '0;
    logic                  avm_readdatavalid = 1'b0;
    logic                  avm_writeresponsevalid = 1'b0;
    logic [1:0]            avm_response = 2'b00;
    logic [2:0]            q_level;
    logic [15:0]           drop_cnt, timeout_cnt;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ltpi_dc_target_bridge #(
        .REQ_FIFO_DEPTH (DEPTH),
        .ADDR_BASE      (32'h0000_0000),
        .ADDR_SIZE      (64),
        .TIMEOUT_CYCLES (TOUT),
        .CNT_W          (16)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .data_channel_rst       (data_channel_rst),
        .local_link_state       (link),
        .req_i                  (req_i),
        .req_i_valid            (req_i_valid),
        .frm_crc_error          (frm_crc_error),
        .resp                   (resp),
        .resp_valid             (resp_valid),
        .resp_ack               (resp_ack),
        .avm_address            (avm_address),
        .avm_read               (avm_read),
        .avm_write              (avm_write),
        .avm_writedata          (avm_writedata),
        .avm_byteenable         (avm_byteenable),
        .avm_waitrequest        (avm_waitrequest),
        .avm_readdata           (avm_readdata),
        .avm_readdatavalid      (avm_readdatavalid),
        .avm_writeresponsevalid (avm_writeresponsevalid),
        .avm_response           (avm_response),
        .q_level                (q_level),
        .drop_cnt               (drop_cnt),
        .timeout_cnt            (timeout_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic Data_channel_payload_t mk(input logic [7:0] t, input dc_command_t c,
                                                 input logic [31:0] a, input logic [7:0] s,
                                                 input logic [3:0] b, input logic [31:0] d);
        Data_channel_payload_t p;
        p.tag = t; p.command = c; p.address = a; p.status = s; p.byte_en = b; p.data = d;
        return p;
    endfunction

    // Scoreboard and response monitor
    Data_channel_payload_t sb[$];
    int resp_seen = 0;
    int last_resp_cyc = 0;

    initial begin
        Data_channel_payload_t e;
        forever begin
            @(negedge clk);
            if (resp_valid && !resp_ack) begin
                resp_seen++;
                last_resp_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got %0h expected none", resp);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("resp_tag%0h", e.tag), resp, e);
                end
                resp_ack = 1'b1;
            end else begin
                resp_ack = 1'b0;
            end
        end
    end

    // Avalon-MM slave model
    int          wait_n = 0;
    bit          stall = 1'b0, no_resp = 1'b0, late_rdv = 1'b0;
    logic [31:0] rd_cfg = '0;
    logic [1:0]  rsp_cfg = 2'b00;
    int          wcnt = 0, last_hold = 0, strobe_total = 0, acc_cnt = 0, strobe_cyc = 0;
    logic [31:0] acc_addr = '0, acc_wdata = '0;
    logic [3:0]  acc_be = '0;
    bit          pend = 1'b0, pend_rd = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            avm_readdatavalid      = 1'b0;
            avm_writeresponsevalid = 1'b0;
            avm_readdata           = '0;
            avm_response           = 2'b00;
            if (pend) begin
                pend = 1'b0;
                if (!no_resp) begin
                    avm_response = rsp_cfg;
                    if (pend_rd) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = rd_cfg;
                    end else begin
                        avm_writeresponsevalid = 1'b1;
                    end
                end
            end
            if (late_rdv) begin
                late_rdv          = 1'b0;
                avm_readdatavalid = 1'b1;
                avm_readdata      = rd_cfg;
            end
            if (avm_read || avm_write) begin
                strobe_total++;
                if (wcnt == 0) strobe_cyc = cyc;
                if (stall || wcnt < wait_n) begin
                    avm_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    pend      = 1'b1;
                    pend_rd   = avm_read;
                    last_hold = wcnt + 1;
                    wcnt      = 0;
                    acc_cnt++;
                    acc_addr  = avm_address;
                    acc_be    = avm_byteenable;
                    acc_wdata = avm_writedata;
                end
            end else begin
                avm_waitrequest = 1'b0;
                wcnt            = 0;
            end
        end
    end

    task automatic send(input Data_channel_payload_t p, input bit crc);
        req_i         = p;
        frm_crc_error = crc;
        req_i_valid   = 1'b1;
        @(negedge clk);
        req_i_valid   = 1'b0;
        frm_crc_error = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || resp_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, n < budget, 1);
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        while (!(avm_read || avm_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_strobe"}, n < 20, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, a0;
        repeat (3) @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp", resp, 0);
        check("rst_avm_strobes", {avm_read, avm_write}, 0);
        check("rst_avm_bus", {avm_address, avm_writedata, avm_byteenable}, 0);
        check("rst_counters", {q_level, drop_cnt, timeout_cnt}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Read with two waitrequest cycles and partial byte enables
        wait_n = 2; rd_cfg = 32'hAABB_CCDD; rsp_cfg = 2'b00;
        sb.push_back(mk(8'h11, READ_COMP, 32'h10, DC_STATUS_OK, 4'b0101, 32'h00BB_00DD));
        send(mk(8'h11, READ_REQ, 32'h10, 8'h00, 4'b0101, 32'h0), 1'b0);
        drain("t1", 50);
        check("t1_hold", last_hold, 3);
        check("t1_addr", acc_addr, 32'h10);
        check("t1_be", acc_be, 4'b0101);

        // Write outside the window: error completion, no bus cycle
        wait_n = 0; s0 = strobe_total;
        sb.push_back(mk(8'h22, WRITE_COMP, 32'h100, DC_STATUS_ERR, 4'hF, 32'h0));
        send(mk(8'h22, WRITE_REQ, 32'h100, 8'h00, 4'hF, 32'hCAFE_F00D), 1'b0);
        drain("t2", 50);
        check("t2_no_bus", strobe_total, s0);

        // Window edges: last valid byte and first byte beyond
        rd_cfg = 32'h1122_3344;
        sb.push_back(mk(8'h23, READ_COMP, 32'h3F, DC_STATUS_OK, 4'hF, 32'h1122_3344));
        send(mk(8'h23, READ_REQ, 32'h3F, 8'h00, 4'hF, 32'h0), 1'b0);
        drain("t2_edge_in", 50);
        s0 = strobe_total;
        sb.push_back(mk(8'h24, READ_COMP, 32'h40, DC_STATUS_ERR, 4'hF, 32'h0));
        send(mk(8'h24, READ_REQ, 32'h40, 8'h00, 4'hF, 32'h0), 1'b0);
        drain("t2_edge_out", 50);
        check("t2_edge_no_bus", strobe_total, s0);

        // CRC-flagged request, then writes with error and OKAY responses
        s0 = strobe_total;
        sb.push_back(mk(8'h33, CRC_ERROR, 32'h4, DC_STATUS_ERR, 4'hF, 32'h0));
        send(mk(8'h33, READ_REQ, 32'h4, 8'h00, 4'hF, 32'h0), 1'b1);
        drain("t5_crc", 50);
        check("t5_crc_no_bus", strobe_total, s0);
        rsp_cfg = 2'b10;
        sb.push_back(mk(8'h34, WRITE_COMP, 32'h8, DC_STATUS_ERR, 4'b1100, 32'h1234_0000));
        send(mk(8'h34, WRITE_REQ, 32'h8, 8'h00, 4'b1100, 32'h1234_5678), 1'b0);
        drain("t5_wr_err", 50);
        check("t5_wdata", acc_wdata, 32'h1234_0000);
        rsp_cfg = 2'b00;
        sb.push_back(mk(8'h35, WRITE_COMP, 32'h3C, DC_STATUS_OK, 4'hF, 32'hDEAD_BEEF));
        send(mk(8'h35, WRITE_REQ, 32'h3C, 8'h00, 4'hF, 32'hDEAD_BEEF), 1'b0);
        drain("t5_wr_ok", 50);

        // Stalled bus: fill the queue, one overflow drop, in-order completions
        stall = 1'b1; wait_n = 0; rd_cfg = 32'h0102_0304;
        sb.push_back(mk(8'h40, READ_COMP, 32'h0, DC_STATUS_OK, 4'hF, 32'h0102_0304));
        send(mk(8'h40, READ_REQ, 32'h0, 8'h00, 4'hF, 32'h0), 1'b0);
        wait_strobe("t3");
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH)
                sb.push_back(mk(8'(8'h40 + i), READ_COMP, 32'(4 * i), DC_STATUS_OK, 4'hF, 32'h0102_0304));
            send(mk(8'(8'h40 + i), READ_REQ, 32'(4 * i), 8'h00, 4'hF, 32'h0), 1'b0);
        end
        check("t3_q_level_peak", q_level, 4);
        check("t3_drop_cnt", drop_cnt, 1);
        stall = 1'b0;
        drain("t3", 150);
        check("t3_drop_cnt_after", drop_cnt, 1);

        // No read data: forced timeout completion, late data ignored
        no_resp = 1'b1;
        sb.push_back(mk(8'h50, READ_COMP, 32'h20, DC_STATUS_ERR, 4'hF, 32'h0));
        send(mk(8'h50, READ_REQ, 32'h20, 8'h00, 4'hF, 32'h0), 1'b0);
        drain("t4", 60);
        check("t4_latency", last_resp_cyc - strobe_cyc, TOUT);
        check("t4_timeout_cnt", timeout_cnt, 1);
        no_resp = 1'b0; r0 = resp_seen; late_rdv = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_late_ignored", resp_seen, r0);
        sb.push_back(mk(8'h51, READ_COMP, 32'h24, DC_STATUS_OK, 4'b0011, 32'h0000_0304));
        send(mk(8'h51, READ_REQ, 32'h24, 8'h00, 4'b0011, 32'h0), 1'b0);
        drain("t4_after", 50);

        // Link drop mid-WAIT with two queued requests
        no_resp = 1'b1; a0 = acc_cnt;
        send(mk(8'h60, READ_REQ, 32'h0, 8'h00, 4'hF, 32'h0), 1'b0);
        for (int n = 0; n < 20 && acc_cnt == a0; n++) @(negedge clk);
        check("t6_accepted", acc_cnt, a0 + 1);
        send(mk(8'h61, READ_REQ, 32'h4, 8'h00, 4'hF, 32'h0), 1'b0);
        send(mk(8'h62, READ_REQ, 32'h8, 8'h00, 4'hF, 32'h0), 1'b0);
        check("t6_q_level_queued", q_level, 2);
        r0 = resp_seen;
        link = link_lost_st;
        repeat (2) @(negedge clk);
        check("t6_q_level_flushed", q_level, 0);
        link = operational_st;
        repeat (25) @(negedge clk);
        check("t6_no_resp", resp_seen, r0);
        check("t6_resp_valid", resp_valid, 0);
        check("t6_timeout_cnt", timeout_cnt, 1);
        no_resp = 1'b0;
        sb.push_back(mk(8'h63, READ_COMP, 32'h2C, DC_STATUS_OK, 4'hF, 32'h0102_0304));
        send(mk(8'h63, READ_REQ, 32'h2C, 8'h00, 4'hF, 32'h0), 1'b0);
        drain("t6_after", 50);

        // Asynchronous reset while the bus cycle is stalled in ISSUE
        stall = 1'b1;
        send(mk(8'h70, READ_REQ, 32'h30, 8'h00, 4'hF, 32'h55), 1'b0);
        wait_strobe("t7");
        #2 reset = 1'b1;
        #1;
        check("t7_strobes", {avm_read, avm_write}, 0);
        check("t7_bus", {avm_address, avm_writedata, avm_byteenable}, 0);
        check("t7_resp", {resp_valid, resp}, 0);
        check("t7_counters", {q_level, drop_cnt, timeout_cnt}, 0);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0;
        @(negedge clk);
        sb.push_back(mk(8'h71, READ_COMP, 32'h14, DC_STATUS_OK, 4'hF, 32'h0102_0304));
        send(mk(8'h71, READ_REQ, 32'h14, 8'h00, 4'hF, 32'h0), 1'b0);
        drain("t7_after", 50);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
